// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD command sequencer.
//   state_t            sequencer FSM states
//   ROM_* constants    layout of an init ROM entry {is_delay, dc, byte}
//   rom_cmd/rom_data/rom_delay  helpers to build 8-bit init tables
//   DEFAULT_INIT_TABLE 16-entry power-up table for a typical TFT controller
//   max_of             helper for sizing counters
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RES_LOW,
    ST_RES_WAIT,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_READY,
    ST_STREAM_WAIT,
    ST_ERROR
  } state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // Entry layout for the 8-bit default tables; the ROM itself derives the
  // same layout from DATA_W: byte in the low bits, then dc, then is_delay.
  localparam int ROM_BYTE_W  = 8;
  localparam int ROM_DC_BIT  = ROM_BYTE_W;
  localparam int ROM_DLY_BIT = ROM_BYTE_W + 1;
  localparam int ROM_ENTRY_W = ROM_BYTE_W + 2;

  localparam int DEFAULT_INIT_LEN = 16;

  function automatic logic [ROM_ENTRY_W-1:0] rom_cmd(input logic [ROM_BYTE_W-1:0] b);
    return {1'b0, DC_CMD, b};
  endfunction

  function automatic logic [ROM_ENTRY_W-1:0] rom_data(input logic [ROM_BYTE_W-1:0] b);
    return {1'b0, DC_DATA, b};
  endfunction

  // Delay in units of DLY_UNIT_CYC; 0 means no wait at all.
  function automatic logic [ROM_ENTRY_W-1:0] rom_delay(input logic [ROM_BYTE_W-1:0] units);
    return {1'b1, 1'b0, units};
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Entry 0 sits in the least significant slice.
  localparam logic [DEFAULT_INIT_LEN*ROM_ENTRY_W-1:0] DEFAULT_INIT_TABLE = {
    rom_cmd(8'h29),    // 15 display on
    rom_delay(8'd10),  // 14
    rom_cmd(8'h13),    // 13 normal display mode
    rom_data(8'h7F),   // 12 column end low
    rom_data(8'h00),   // 11 column end high
    rom_data(8'h00),   // 10 column start low
    rom_data(8'h00),   //  9 column start high
    rom_cmd(8'h2A),    //  8 column address set
    rom_data(8'hC8),   //  7 memory access control value
    rom_cmd(8'h36),    //  6 memory access control
    rom_data(8'h05),   //  5 16 bpp
    rom_cmd(8'h3A),    //  4 pixel format
    rom_delay(8'd120), //  3
    rom_cmd(8'h11),    //  2 sleep out
    rom_delay(8'd150), //  1
    rom_cmd(8'h01)     //  0 software reset
  };

endpackage

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: combinational init-table lookup.
//   idx       in   entry index
//   is_delay  out  entry is a delay (data = delay units)
//   dc        out  DC value for a byte entry
//   data      out  byte to send, or delay units
// Out-of-range indices read as an all-zero entry.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int INIT_LEN = 16,
  parameter int IDX_W    = 4,
  parameter logic [INIT_LEN*(DATA_W+2)-1:0] TABLE = '0
) (
  input  logic [IDX_W-1:0]  idx,
  output logic              is_delay,
  output logic              dc,
  output logic [DATA_W-1:0] data
);

  localparam int ENTRY_W = DATA_W + 2;

  logic [ENTRY_W-1:0] entry;

  always_comb begin
    entry = '0;
    for (int i = 0; i < INIT_LEN; i++) begin
      if (idx == IDX_W'(i)) entry = TABLE[i*ENTRY_W +: ENTRY_W];
    end
  end

  assign data     = entry[DATA_W-1:0];
  assign dc       = entry[DATA_W];
  assign is_delay = entry[DATA_W+1];

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: drives the panel reset pulse, replays the init ROM
// through the SPI master send/done handshake, then forwards user bytes.
//   clk, rst          clock, synchronous active-high reset
//   start             begin reset+init (accepted in IDLE/READY/ERROR)
//   spi_data/spi_send byte and one-cycle request to the SPI master
//   spi_done          byte-complete pulse from the SPI master
//   lcd_dc, lcd_res   panel DC line and active-low hardware reset
//   wr_valid/wr_dc/wr_data/wr_ready  user byte port
//   init_done, busy, error           status
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int RES_LOW_CYC  = 2500,
  parameter int RES_WAIT_CYC = 30000,
  parameter int DLY_UNIT_CYC = 250,
  parameter int INIT_LEN     = 16,
  parameter int TIMEOUT_CYC  = 4096,
  parameter logic [INIT_LEN*(DATA_W+2)-1:0] INIT_TABLE = DEFAULT_INIT_TABLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [DATA_W-1:0] spi_data,
  output logic              spi_send,
  input  logic              spi_done,
  output logic              lcd_dc,
  output logic              lcd_res,
  input  logic              wr_valid,
  input  logic              wr_dc,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              init_done,
  output logic              busy,
  output logic              error
);

  localparam int CNT_MAX = max_of(max_of(RES_LOW_CYC, RES_WAIT_CYC),
                                  max_of(255 * DLY_UNIT_CYC, TIMEOUT_CYC));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  state_t            state, state_nxt;
  cnt_t              cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              dc_q, dc_nxt;
  logic              send_q, send_nxt;
  logic              err_q, err_nxt;
  logic              init_q, init_nxt;

  logic              rom_dly, rom_dc;
  logic [DATA_W-1:0] rom_byte;
  logic              last_entry, start_ok, timed_out;

  lcd_init_rom #(
    .DATA_W  (DATA_W),
    .INIT_LEN(INIT_LEN),
    .IDX_W   (IDX_W),
    .TABLE   (INIT_TABLE)
  ) u_rom (
    .idx     (idx),
    .is_delay(rom_dly),
    .dc      (rom_dc),
    .data    (rom_byte)
  );

  assign start_ok   = start && (state inside {ST_IDLE, ST_READY, ST_ERROR});
  assign last_entry = (idx == IDX_W'(INIT_LEN - 1));
  assign timed_out  = (cnt == cnt_t'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx    <= '0;
      data_q <= '0;
      dc_q   <= 1'b0;
      send_q <= 1'b0;
      err_q  <= 1'b0;
      init_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      data_q <= data_nxt;
      dc_q   <= dc_nxt;
      send_q <= send_nxt;
      err_q  <= err_nxt;
      init_q <= init_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    data_nxt  = data_q;
    dc_nxt    = dc_q;
    send_nxt  = 1'b0;
    err_nxt   = err_q;
    init_nxt  = init_q;

    if (start_ok) begin
      state_nxt = ST_RES_LOW;
      cnt_nxt   = '0;
      err_nxt   = 1'b0;
      init_nxt  = 1'b0;
    end else begin
      unique case (state)
        ST_RES_LOW: begin
          if (cnt == cnt_t'(RES_LOW_CYC - 1)) begin
            state_nxt = ST_RES_WAIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + cnt_t'(1);
          end
        end

        ST_RES_WAIT: begin
          if (cnt == cnt_t'(RES_WAIT_CYC - 1)) begin
            state_nxt = ST_LOAD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            cnt_nxt = cnt + cnt_t'(1);
          end
        end

        ST_LOAD: begin
          if (!rom_dly) begin
            data_nxt  = rom_byte;
            dc_nxt    = rom_dc;
            send_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_WAIT_DONE;
          end else if (rom_byte == '0) begin
            // Zero-length delay: skip straight to the next entry.
            state_nxt = last_entry ? ST_READY : ST_LOAD;
            idx_nxt   = last_entry ? idx : idx + IDX_W'(1);
            init_nxt  = last_entry;
          end else begin
            // Count down to zero inclusive, so preload total-1.
            cnt_nxt   = cnt_t'(rom_byte) * cnt_t'(DLY_UNIT_CYC) - cnt_t'(1);
            state_nxt = ST_DELAY;
          end
        end

        ST_WAIT_DONE: begin
          if (spi_done) begin
            state_nxt = last_entry ? ST_READY : ST_LOAD;
            idx_nxt   = last_entry ? idx : idx + IDX_W'(1);
            init_nxt  = last_entry;
          end else if (timed_out) begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + cnt_t'(1);
          end
        end

        ST_DELAY: begin
          if (cnt == '0) begin
            state_nxt = last_entry ? ST_READY : ST_LOAD;
            idx_nxt   = last_entry ? idx : idx + IDX_W'(1);
            init_nxt  = last_entry;
          end else begin
            cnt_nxt = cnt - cnt_t'(1);
          end
        end

        ST_READY: begin
          if (wr_valid) begin
            data_nxt  = wr_data;
            dc_nxt    = wr_dc;
            send_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_STREAM_WAIT;
          end
        end

        ST_STREAM_WAIT: begin
          if (spi_done) begin
            state_nxt = ST_READY;
          end else if (timed_out) begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + cnt_t'(1);
          end
        end

        default: ;
      endcase
    end
  end

  assign spi_data  = data_q;
  assign spi_send  = send_q;
  assign lcd_dc    = dc_q;
  assign lcd_res   = (state != ST_RES_LOW);
  assign wr_ready  = (state == ST_READY);
  assign init_done = init_q;
  assign busy      = !(state inside {ST_IDLE, ST_READY, ST_ERROR});
  assign error     = err_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a deadline-based model.
module tb_lcd_cmd_sequencer;

  localparam int DATA_W   = 8;
  localparam int RES_LOW  = 4;
  localparam int RES_WAIT = 6;
  localparam int UNIT     = 3;
  localparam int LEN      = 3;
  localparam int TMO      = 20;
  // {is_delay, dc, byte} per entry, entry 0 in the low bits:
  // cmd 0x11, delay 2 units, data 0xA5
  localparam logic [LEN*(DATA_W+2)-1:0] TABLE = {2'b01, 8'hA5, 2'b10, 8'h02, 2'b00, 8'h11};

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, spi_done = 1'b0;
  logic wr_valid = 1'b0, wr_dc = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] spi_data;
  logic spi_send, lcd_dc, lcd_res, wr_ready, init_done, busy, error;

  always #5 clk = ~clk;

  lcd_cmd_sequencer #(
    .DATA_W(DATA_W), .RES_LOW_CYC(RES_LOW), .RES_WAIT_CYC(RES_WAIT),
    .DLY_UNIT_CYC(UNIT), .INIT_LEN(LEN), .TIMEOUT_CYC(TMO), .INIT_TABLE(TABLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .spi_data(spi_data), .spi_send(spi_send), .spi_done(spi_done),
    .lcd_dc(lcd_dc), .lcd_res(lcd_res),
    .wr_valid(wr_valid), .wr_dc(wr_dc), .wr_data(wr_data), .wr_ready(wr_ready),
    .init_done(init_done), .busy(busy), .error(error)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SPI master stand-in ----------------
  int  lat = 10;       // done arrives lat cycles after send; 0 = never
  int  pend = 0;
  logic inj = 1'b0;    // extra done pulse requested by stimulus
  always @(negedge clk) begin
    logic fire;
    fire = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) fire = 1'b1;
    end
    if (spi_send) pend = lat;
    spi_done = fire | inj;
  end

  // ---------------- reference model ----------------
  // Phases with absolute-cycle deadlines instead of counters.
  localparam int P_IDLE = 0, P_RESLO = 1, P_RESWT = 2, P_FETCH = 3, P_DLY = 4,
                 P_XFER = 5, P_READY = 6, P_STRM = 7, P_ERR = 8;
  logic [7:0] m_b   [LEN] = '{8'h11, 8'h02, 8'hA5};
  bit         m_dly [LEN] = '{1'b0, 1'b1, 1'b0};
  bit         m_dc  [LEN] = '{1'b0, 1'b0, 1'b1};

  int now = 0, ph = P_IDLE, t_end = 0, ptr = 0;
  logic [7:0] e_data = 8'h00;
  logic e_dc = 1'b0, e_send = 1'b0, e_err = 1'b0, e_init = 1'b0;
  bit m_live = 1'b0;

  task automatic next_entry();
    if (ptr == LEN - 1) begin
      ph = P_READY;
      e_init = 1'b1;
    end else begin
      ptr++;
      ph = P_FETCH;
    end
  endtask

  always @(posedge clk) begin
    now++;
    e_send = 1'b0;
    if (rst) begin
      ph = P_IDLE; ptr = 0; e_data = 8'h00; e_dc = 1'b0;
      e_err = 1'b0; e_init = 1'b0; m_live = 1'b1;
    end else if (start && (ph == P_IDLE || ph == P_READY || ph == P_ERR)) begin
      ph = P_RESLO; t_end = now + RES_LOW; e_err = 1'b0; e_init = 1'b0;
    end else begin
      case (ph)
        P_RESLO: if (now == t_end) begin ph = P_RESWT; t_end = now + RES_WAIT; end
        P_RESWT: if (now == t_end) begin ph = P_FETCH; ptr = 0; end
        P_FETCH: begin
          if (m_dly[ptr]) begin
            if (m_b[ptr] == 8'd0) next_entry();
            else begin ph = P_DLY; t_end = now + int'(m_b[ptr]) * UNIT; end
          end else begin
            e_send = 1'b1; e_data = m_b[ptr]; e_dc = m_dc[ptr];
            ph = P_XFER; t_end = now + TMO;
          end
        end
        P_DLY:  if (now == t_end) next_entry();
        P_XFER: begin
          if (spi_done) next_entry();
          else if (now == t_end) begin ph = P_ERR; e_err = 1'b1; end
        end
        P_READY: if (wr_valid) begin
          e_send = 1'b1; e_data = wr_data; e_dc = wr_dc;
          ph = P_STRM; t_end = now + TMO;
        end
        P_STRM: begin
          if (spi_done) ph = P_READY;
          else if (now == t_end) begin ph = P_ERR; e_err = 1'b1; end
        end
        default: ;
      endcase
    end
  end

  // ---------------- compare + event recorder ----------------
  int   s_cyc[$];
  logic [7:0] s_data[$];
  logic s_dc[$];
  int   res_fell = 0, res_rose = 0, err_at = 0, init_at = 0;
  logic p_res = 1'b1, p_err = 1'b0, p_init = 1'b0;

  always @(negedge clk) begin
    if (m_live) begin
      chk("spi_send",  spi_send,  e_send);
      chk("spi_data",  spi_data,  e_data);
      chk("lcd_dc",    lcd_dc,    e_dc);
      chk("lcd_res",   lcd_res,   ph != P_RESLO);
      chk("wr_ready",  wr_ready,  ph == P_READY);
      chk("busy",      busy,      !(ph == P_IDLE || ph == P_READY || ph == P_ERR));
      chk("init_done", init_done, e_init);
      chk("error",     error,     e_err);
    end
    if (spi_send) begin s_cyc.push_back(now); s_data.push_back(spi_data); s_dc.push_back(lcd_dc); end
    if (p_res && !lcd_res) res_fell = now;
    if (!p_res && lcd_res) res_rose = now;
    if (!p_err && error) err_at = now;
    if (!p_init && init_done) init_at = now;
    p_res = lcd_res; p_err = error; p_init = init_done;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_done();
    inj = 1'b1; tick(); inj = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_spi_send"}, spi_send, 0);
    chk({tag, "_spi_data"}, spi_data, 0);
    chk({tag, "_lcd_dc"}, lcd_dc, 0);
    chk({tag, "_lcd_res"}, lcd_res, 1);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    int k, hs_at;
    rst = 1'b1; tick(3);
    chk_reset_vals("reset");
    rst = 1'b0; tick(2);

    // spurious done while idle
    pulse_done(); tick();
    chk("idle_spurious_busy", busy, 0);
    chk("idle_spurious_sends", s_cyc.size(), 0);

    // init sequence
    pulse_start();
    k = 0; while (!init_done && k < 500) begin tick(); k++; end
    chk("init_reached", init_done, 1);
    chk("res_low_cycles", res_rose - res_fell, 4);
    chk("init_send_count", s_cyc.size(), 2);
    if (s_cyc.size() >= 2) begin
      chk("first_send_after_res", s_cyc[0] - res_rose, 7);
      chk("send0_data", s_data[0], 8'h11);
      chk("send0_dc", s_dc[0], 0);
      // done sampled 11 cycles after send, then load, 6-cycle delay, load, send
      chk("send_gap", s_cyc[1] - s_cyc[0], 19);
      chk("send1_data", s_data[1], 8'hA5);
      chk("send1_dc", s_dc[1], 1);
      chk("init_after_last_done", init_at - s_cyc[1], 11);
    end
    chk("ready_after_init", wr_ready, 1);

    // user byte
    wr_valid = 1'b1; wr_dc = 1'b1; wr_data = 8'h3C; tick(); wr_valid = 1'b0;
    chk("hs_ready_drop", wr_ready, 0);
    chk("hs_send", spi_send, 1);
    chk("hs_data", spi_data, 8'h3C);
    chk("hs_dc", lcd_dc, 1);
    k = 0; while (!spi_done && k < 100) begin tick(); k++; end
    chk("hs_done_seen", spi_done, 1);
    chk("hs_ready_during_done", wr_ready, 0);
    tick();
    chk("hs_ready_back", wr_ready, 1);
    chk("hs_one_send", s_cyc.size(), 3);

    // spurious done while ready
    pulse_done(); tick();
    chk("ready_spurious_ready", wr_ready, 1);
    chk("ready_spurious_sends", s_cyc.size(), 3);

    // timeout
    lat = 0;
    wr_valid = 1'b1; wr_dc = 1'b0; wr_data = 8'h5A; tick(); wr_valid = 1'b0;
    hs_at = now;
    k = 0; while (!error && k < 100) begin tick(); k++; end
    chk("tmo_error", error, 1);
    chk("tmo_latency", err_at - hs_at, 20);
    chk("tmo_wr_ready", wr_ready, 0);
    chk("tmo_busy", busy, 0);
    lat = 10;
    pulse_start();
    chk("restart_error_clr", error, 0);
    chk("restart_res_low", lcd_res, 0);
    chk("restart_init_clr", init_done, 0);

    // start during RES_WAIT is ignored
    k = 0; while (!lcd_res && k < 50) begin tick(); k++; end
    tick(2);
    pulse_start();
    k = 0; while (s_cyc.size() < 5 && k < 100) begin tick(); k++; end
    chk("reswait_start_sends", s_cyc.size(), 5);
    if (s_cyc.size() >= 5) begin
      chk("reswait_start_timing", s_cyc[4] - res_rose, 7);
      chk("reswait_send_data", s_data[4], 8'h11);
    end

    // reset during WAIT_DONE
    tick(2);
    rst = 1'b1; tick();
    chk_reset_vals("midrst");
    rst = 1'b0; tick(15);
    pulse_start();
    k = 0; while (s_cyc.size() < 6 && k < 100) begin tick(); k++; end
    chk("replay_sends", s_cyc.size(), 6);
    if (s_cyc.size() >= 6) chk("replay_data", s_data[5], 8'h11);
    k = 0; while (!init_done && k < 500) begin tick(); k++; end
    chk("replay_init", init_done, 1);

    // randomized traffic; the per-cycle compare does the checking
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      start    = ($urandom_range(0, 149) == 0);
      wr_valid = ($urandom_range(0, 9) < 4);
      wr_dc    = $urandom_range(0, 1);
      wr_data  = 8'($urandom);
      inj      = ($urandom_range(0, 39) == 0);
      lat      = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 22);
      tick();
    end
    rst = 1'b0; start = 1'b0; wr_valid = 1'b0; inj = 1'b0;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
